if_stage: RTL
=============

# if_stage

Instruction-fetch stage plus IF/ID pipeline register. It owns the program counter, presents the fetch address to instruction memory, and registers the fetched word for the decode stage. It accepts a hazard stall and a taken-branch redirect from decode. It sits directly upstream of decode: its `instruction` output drives decode's `instruction` input, and decode's `beq_taken`/`imm` outputs return here.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address fetched first after reset; must be word-aligned.
- `NOP_WORD`, default 32'h0000_0000: word loaded into IF/ID on a squash.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hold PC and IF/ID (load-use hazard from hazard unit).
- `beq_taken` in 1: branch-taken from decode for the instruction currently in IF/ID.
- `branch_imm` in 32: sign-extended 16-bit offset from decode (word offset).
- `imem_addr` out 32: byte fetch address; equals `pc`.
- `imem_rdata` in 32: instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `pc` out 32: current fetch PC.
- `instruction` out 32: IF/ID instruction register, feeding decode.
- `pc_plus4_id` out 32: IF/ID copy of (fetch PC + 4) for the instruction in decode.
- `id_valid` out 1: IF/ID holds a real instruction, not a bubble.
- `fetch_count` out 32: number of instructions loaded into IF/ID as valid.

## Operation
- Reset (async, immediate) sets:
  - `pc` = RESET_PC, `instruction` = NOP_WORD, `pc_plus4_id` = 0, `id_valid` = 0, `fetch_count` = 0.
- Branch target = `pc_plus4_id` + {`branch_imm`[29:0], 2'b00}, computed mod 2^32.
- A redirect occurs when `beq_taken` && `id_valid` && !`stall`.
- Each rising edge applies the first matching case:
  1. `stall`=1: all registers hold. `beq_taken` is ignored, because decode operands are stale during a stall and the branch re-evaluates once the stall clears.
  2. Redirect:
     - `pc` ← target.
     - `instruction` ← NOP_WORD, `id_valid` ← 0. The wrong-path word being fetched is squashed.
     - `pc_plus4_id` ← `pc` + 4.
     - `fetch_count` holds.
  3. Normal:
     - `pc` ← `pc` + 4.
     - `instruction` ← `imem_rdata`, `pc_plus4_id` ← `pc` + 4, `id_valid` ← 1.
     - `fetch_count` ← `fetch_count` + 1.
- `beq_taken` while `id_valid`=0 is ignored. A bubble cannot redirect.
- Arithmetic:
  - PC + 4 wraps 32'hFFFF_FFFC → 0 with no flag.
  - Target addition wraps mod 2^32.
  - `fetch_count` wraps at 2^32.
  - PC[1:0] stays 00 because RESET_PC is aligned and the offset is shifted.
- No internal FSM beyond the PC/IF-ID registers. Decode's state is {valid, bubble}, controlled by `id_valid`.

## Timing
- Fetch-to-decode latency is 1 cycle. The word at `imem_addr` in cycle N appears on `instruction` in cycle N+1.
- `imem_addr` is combinational from the `pc` register, with no extra delay.
- Taken-branch penalty is exactly 1 bubble cycle:
  - Branch in decode at cycle N.
  - Bubble in decode at N+1.
  - Target instruction in decode at N+2.
- A stall held for K cycles freezes every output for K cycles. Normal advance or redirect resumes on the first edge with `stall`=0.
- Reset asserted mid-cycle forces reset values immediately, without waiting for an edge.
- After reset deassertion, the first rising edge performs a normal fetch of RESET_PC.
- `stall` and `beq_taken` are sampled only at rising edges, and the block adds no combinational path from them to `imem_addr`.

## Test plan
- Sequential fetch: imem[0]=32'h8C01_0004, imem[4]=32'h0022_1820, then release reset.
  - Edge 1: `instruction`=32'h8C01_0004, `pc_plus4_id`=4, `pc`=4, `id_valid`=1, `fetch_count`=1.
  - Edge 2: `instruction`=32'h0022_1820, `pc`=8.
- Stall: with `pc`=8, hold `stall`=1 for 2 edges.
  - `pc`, `instruction`, `pc_plus4_id` and `fetch_count`=2 are unchanged.
  - On release, the next edge loads imem[8] and `pc`=12.
- Forward branch: `pc_plus4_id`=12, `id_valid`=1, `beq_taken`=1, `branch_imm`=3.
  - Next edge: `pc`=24, `instruction`=NOP_WORD, `id_valid`=0, `fetch_count` unchanged.
  - Following edge: `instruction`=imem[24], `pc_plus4_id`=28.
- Backward branch and bubble: `pc_plus4_id`=12, `branch_imm`=32'hFFFF_FFFD gives `pc`=0. Then `beq_taken`=1 while `id_valid`=0 must give `pc`=4, with no redirect.
- Stall and branch together: `stall`=1 with `beq_taken`=1 gives a hold. The next edge with `stall`=0 and `beq_taken`=1 redirects to the target.
- Async reset mid-run:
  - Assert `reset` between edges at `pc`=40: all outputs take reset values before the next edge.
  - Deassert: the first edge fetches RESET_PC, including with a nonzero RESET_PC=32'h100.
  - Wrap: force `pc`=32'hFFFF_FFFC and step; `pc`=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, presents it as the fetch address, and registers the fetched
// word plus its PC+4 for decode. Honors hazard stalls and taken-branch redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        beq_taken,
  input  logic [31:0] branch_imm,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4_id,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  // Modulo-2^32 address addition; carries out of bit 31 are discarded.
  function automatic logic [31:0] add_wrap(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[31:0];
  endfunction

  // Word offset to byte offset; the two top bits fall off, which is harmless
  // because the sum is taken modulo 2^32 anyway.
  function automatic logic [31:0] word_to_byte(input logic signed [31:0] off);
    return {off[29:0], 2'b00};
  endfunction

  logic [31:0] pc_plus4_p0;
  logic [31:0] target_p0;
  logic        redirect_p0;

  // Fetch-side next-address arithmetic; stall/branch never reach imem_addr.
  always_comb begin
    pc_plus4_p0 = add_wrap(pc, 32'd4);
    target_p0   = add_wrap(pc_plus4_id, word_to_byte(branch_imm));
    redirect_p0 = beq_taken && id_valid && !stall;
  end

  assign imem_addr = pc;

  // ---- IF -> ID boundary ----
  // PC and IF/ID update: stall holds everything, redirect squashes the
  // wrong-path word into a bubble, otherwise advance sequentially.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      instruction <= NOP_WORD;
      pc_plus4_id <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (stall) begin
      pc          <= pc;
      instruction <= instruction;
      pc_plus4_id <= pc_plus4_id;
      id_valid    <= id_valid;
      fetch_count <= fetch_count;
    end else if (redirect_p0) begin
      pc          <= target_p0;
      instruction <= NOP_WORD;
      pc_plus4_id <= pc_plus4_p0;
      id_valid    <= 1'b0;
      fetch_count <= fetch_count;
    end else begin
      pc          <= pc_plus4_p0;
      instruction <= imem_rdata;
      pc_plus4_id <= pc_plus4_p0;
      id_valid    <= 1'b1;
      fetch_count <= add_wrap(fetch_count, 32'd1);
    end
  end

endmodule
